// File: rtl/k12a_pkg.sv
// k12a_pkg: shared state encoding, access-state predicate and wait-width default.
//   state_t          3-bit control-path state
//   is_access_state  true for the states that drive a memory/IO access
package k12a_pkg;
   localparam int WAIT_W_DEFAULT = 3;
   typedef logic [2:0] state_t;
   localparam state_t STATE_FETCH1  = 3'd0;
   localparam state_t STATE_FETCH2  = 3'd1;
   localparam state_t STATE_DATA    = 3'd2;
   localparam state_t STATE_EXECUTE = 3'd3;
   localparam state_t STATE_HALT    = 3'd4;
   function automatic logic is_access_state(input state_t s);
      return s == STATE_FETCH1 || s == STATE_FETCH2 || s == STATE_DATA;
   endfunction
endpackage

// File: rtl/k12a_resume_sync.sv
// k12a_resume_sync: synchronises the asynchronous resume level and emits a one-cycle rising-edge pulse.
//   cpu_clock, reset  clock and asynchronous active-high reset
//   resume            asynchronous run/step request level
//   resume_pulse      one-cycle pulse on a synchronised rising edge
module k12a_resume_sync (
   input  logic cpu_clock,
   input  logic reset,
   input  logic resume,
   output logic resume_pulse
);
   logic sync1, sync2, prev;
   // Reset to ones so a resume held high through reset yields no pulse.
   always_ff @(posedge cpu_clock or posedge reset)
      if (reset) {sync1, sync2, prev} <= 3'b111;
      else {sync1, sync2, prev} <= {resume, sync1, sync2};
   assign resume_pulse = sync2 & ~prev;
endmodule

// File: rtl/k12a_sequencer.sv
// k12a_sequencer: next-state, wait-state and halt/resume logic for the K12A control path.
//   cpu_clock, reset   clock and asynchronous active-high reset
//   state/state_next   current state in, next state out (to the external state register)
//   mem_ready          device ready; inst_is_mem / inst_is_halt from decode
//   resume             asynchronous run/step request
//   wait_cycles        extra cycles per access (only with K12A_WAIT_STATES_EN)
//   mem_access, inst_hi_load, inst_lo_load, halted  decoded outputs
// Build option: K12A_WAIT_STATES_EN adds the wait_cycles port and wait counter.
module k12a_sequencer
   import k12a_pkg::*;
#(
   parameter int WAIT_W = WAIT_W_DEFAULT
) (
   input  logic              cpu_clock,
   input  logic              reset,
   input  state_t            state,
   input  logic              mem_ready,
   input  logic              inst_is_mem,
   input  logic              inst_is_halt,
   input  logic              resume,
`ifdef K12A_WAIT_STATES_EN
   input  logic [WAIT_W-1:0] wait_cycles,
`endif
   output state_t            state_next,
   output logic              mem_access,
   output logic              inst_hi_load,
   output logic              inst_lo_load,
   output logic              halted
);
   logic [WAIT_W-1:0] wait_cnt;
   logic access_done, resume_pulse;
   state_t next_raw;
   k12a_resume_sync u_resume_sync (
      .cpu_clock(cpu_clock),
      .reset(reset),
      .resume(resume),
      .resume_pulse(resume_pulse)
   );
   assign mem_access  = is_access_state(state);
   assign access_done = mem_access & mem_ready & (wait_cnt == '0);
   assign next_raw =
      state == STATE_FETCH1  ? (access_done ? STATE_FETCH2 : STATE_FETCH1) :
      state == STATE_FETCH2  ? (access_done ? (inst_is_mem ? STATE_DATA : STATE_EXECUTE) : STATE_FETCH2) :
      state == STATE_DATA    ? (access_done ? STATE_FETCH1 : STATE_DATA) :
      state == STATE_EXECUTE ? (inst_is_halt ? STATE_HALT : STATE_FETCH1) :
      state == STATE_HALT    ? (resume_pulse ? STATE_FETCH1 : STATE_HALT) :
      STATE_FETCH1;
   assign state_next   = reset ? STATE_FETCH1 : next_raw;
   assign inst_hi_load = (state == STATE_FETCH1) & access_done & ~reset;
   assign inst_lo_load = (state == STATE_FETCH2) & access_done & ~reset;
   assign halted       = state == STATE_HALT;
`ifdef K12A_WAIT_STATES_EN
   // Reload on entry to an access and after each completed access; the count
   // free-runs down to zero regardless of mem_ready.
   always_ff @(posedge cpu_clock or posedge reset)
      if (reset) wait_cnt <= '1;
      else if (is_access_state(next_raw) && (next_raw != state || access_done)) wait_cnt <= wait_cycles;
      else if (wait_cnt != '0) wait_cnt <= wait_cnt - WAIT_W'(1);
`else
   assign wait_cnt = '0;
`endif
endmodule

// File: tb/tb_k12a_sequencer.sv
// tb_k12a_sequencer: self-checking bench for k12a_sequencer with an external state register and a reference model.
module tb_k12a_sequencer;
   import k12a_pkg::*;
`ifdef K12A_WAIT_STATES_EN
   localparam int WS = 1;
`else
   localparam int WS = 0;
`endif
   logic cpu_clock = 0, clk_en = 1, reset = 0, use_force = 0;
   logic mem_ready = 0, inst_is_mem = 0, inst_is_halt = 0, resume = 0;
   logic [2:0] wc = 0;
   state_t st_reg, force_st, state, state_next;
   logic mem_access, inst_hi_load, inst_lo_load, halted;
   int checks = 0, failures = 0;
   state_t m_st;
   int m_el, m_need;
   logic [2:0] hist;
   typedef struct {
      state_t st;
      logic rdy, mem, hlt;
      state_t nx;
      logic acc, hi, lo, hl;
   } vec_t;
   vec_t tbl[14];

   k12a_sequencer dut (
      .cpu_clock(cpu_clock),
      .reset(reset),
      .state(state),
      .mem_ready(mem_ready),
      .inst_is_mem(inst_is_mem),
      .inst_is_halt(inst_is_halt),
      .resume(resume),
`ifdef K12A_WAIT_STATES_EN
      .wait_cycles(wc),
`endif
      .state_next(state_next),
      .mem_access(mem_access),
      .inst_hi_load(inst_hi_load),
      .inst_lo_load(inst_lo_load),
      .halted(halted)
   );

   always #5 if (clk_en) cpu_clock = ~cpu_clock;
   always_ff @(posedge cpu_clock or posedge reset)
      if (reset) st_reg <= STATE_FETCH1;
      else st_reg <= state_next;
   assign state = use_force ? force_st : st_reg;

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: an access completes once the device is ready and at
   // least `need` cycles have elapsed since the access began.
   task automatic mdl_reset();
      m_st = STATE_FETCH1;
      m_el = 0;
      m_need = WS ? 7 : 0;
      hist = 3'b111;
   endtask

   function automatic state_t m_next(input logic done, input logic pulse);
      if (reset) return STATE_FETCH1;
      case (m_st)
         STATE_FETCH1:  return done ? STATE_FETCH2 : STATE_FETCH1;
         STATE_FETCH2:  return done ? (inst_is_mem ? STATE_DATA : STATE_EXECUTE) : STATE_FETCH2;
         STATE_DATA:    return done ? STATE_FETCH1 : STATE_DATA;
         STATE_EXECUTE: return inst_is_halt ? STATE_HALT : STATE_FETCH1;
         STATE_HALT:    return pulse ? STATE_FETCH1 : STATE_HALT;
         default:       return STATE_FETCH1;
      endcase
   endfunction

   // One clock cycle: entered just after a negedge with inputs already driven.
   task automatic cyc();
      logic acc, done, pulse;
      state_t nx;
      #2;
      if (reset) mdl_reset();
      acc = m_st inside {STATE_FETCH1, STATE_FETCH2, STATE_DATA};
      done = acc && mem_ready && m_el >= m_need && !reset;
      pulse = hist[1] && !hist[2];
      nx = m_next(done, pulse);
      chk("state_next", 32'(state_next), 32'(nx));
      chk("mem_access", 32'(mem_access), 32'(acc));
      chk("inst_hi_load", 32'(inst_hi_load), 32'(done && m_st == STATE_FETCH1));
      chk("inst_lo_load", 32'(inst_lo_load), 32'(done && m_st == STATE_FETCH2));
      chk("halted", 32'(halted), 32'(m_st == STATE_HALT));
      @(posedge cpu_clock);
      if (reset) mdl_reset();
      else begin
         if (nx != m_st || done) begin
            m_el = 0;
            m_need = WS ? int'(wc) : 0;
         end else m_el++;
         m_st = nx;
         hist = {hist[1:0], resume};
      end
      @(negedge cpu_clock);
   endtask

   task automatic run_until(input state_t s, input string nm);
      int n = 0;
      while (state != s && n < 60) begin
         cyc();
         n++;
      end
      chk({"reach_", nm}, 32'(state), 32'(s));
   endtask

   task automatic measure(input state_t s, output int n);
      n = 0;
      while (state == s && n < 50) begin
         cyc();
         n++;
      end
   endtask

   initial begin
      int n;
      mdl_reset();
      reset = 1;
      resume = 1;
      mem_ready = 1;
      @(negedge cpu_clock);
      repeat (3) cyc();
      reset = 0;
      n = 0;
      forever begin
         #1;
         if (inst_hi_load || n >= 20) break;
         cyc();
         n++;
      end
      chk("first_fetch_wait", 32'(n), 32'(WS ? 7 : 0));
      run_until(STATE_EXECUTE, "exec_a");
      wc = 2;
      cyc();
      measure(STATE_FETCH1, n);
      chk("fetch1_len", 32'(n), 32'(WS ? 3 : 1));
      measure(STATE_FETCH2, n);
      chk("fetch2_len", 32'(n), 32'(WS ? 3 : 1));
      chk("after_fetch2", 32'(state), 32'(STATE_EXECUTE));
      wc = 0;
      inst_is_mem = 1;
      resume = 0;
      run_until(STATE_DATA, "data");
      mem_ready = 0;
      repeat (5) begin
         cyc();
         chk("data_hold", 32'(state), 32'(STATE_DATA));
      end
      mem_ready = 1;
      cyc();
      chk("data_exit", 32'(state), 32'(STATE_FETCH1));
      inst_is_mem = 0;
      run_until(STATE_EXECUTE, "exec_d");
      cyc();
      chk("halt_seq_start", 32'(state), 32'(STATE_FETCH1));
      inst_is_halt = 1;
      resume = 1;
      cyc();
      cyc();
      chk("halt_exec", 32'(state), 32'(STATE_EXECUTE));
      cyc();
      chk("halt_enter", 32'(state), 32'(STATE_HALT));
      inst_is_halt = 0;
      repeat (6) cyc();
      #1;
      chk("halt_stay", 32'(halted), 32'(1));
      resume = 0;
      repeat (3) cyc();
      resume = 1;
      n = 0;
      forever begin
         #1;
         if (!halted || n >= 10) break;
         cyc();
         n++;
      end
      chk("resume_latency", 32'(n >= 3 && n <= 4), 32'(1));
      chk("resume_exit", 32'(state), 32'(STATE_FETCH1));
      wc = 2;
      run_until(STATE_FETCH2, "fetch2_r");
      cyc();
      reset = 1;
      #1;
      chk("reset_next", 32'(state_next), 32'(STATE_FETCH1));
      chk("reset_lo", 32'(inst_lo_load), 32'(0));
      cyc();
      reset = 0;
      measure(STATE_FETCH1, n);
      chk("reset_fetch1_len", 32'(n), 32'(WS ? 8 : 1));
      for (int i = 0; i < 500; i++) begin
         mem_ready = $urandom_range(0, 3) != 0;
         inst_is_mem = 1'($urandom);
         inst_is_halt = $urandom_range(0, 3) == 0;
         if ($urandom_range(0, 7) == 0) resume = ~resume;
         if ($urandom_range(0, 15) == 0) wc = 3'($urandom);
         reset = $urandom_range(0, 99) == 0;
         cyc();
      end
      reset = 0;
      wc = 0;
      resume = 0;
      mem_ready = 1;
      inst_is_halt = 0;
      repeat (12) cyc();
      clk_en = 0;
      use_force = 1;
      tbl[0]  = '{STATE_FETCH1,  1, 0, 0, STATE_FETCH2,  1, 1, 0, 0};
      tbl[1]  = '{STATE_FETCH1,  0, 0, 0, STATE_FETCH1,  1, 0, 0, 0};
      tbl[2]  = '{STATE_FETCH2,  1, 0, 0, STATE_EXECUTE, 1, 0, 1, 0};
      tbl[3]  = '{STATE_FETCH2,  1, 1, 0, STATE_DATA,    1, 0, 1, 0};
      tbl[4]  = '{STATE_FETCH2,  0, 1, 0, STATE_FETCH2,  1, 0, 0, 0};
      tbl[5]  = '{STATE_DATA,    1, 0, 0, STATE_FETCH1,  1, 0, 0, 0};
      tbl[6]  = '{STATE_DATA,    0, 0, 1, STATE_DATA,    1, 0, 0, 0};
      tbl[7]  = '{STATE_EXECUTE, 0, 0, 0, STATE_FETCH1,  0, 0, 0, 0};
      tbl[8]  = '{STATE_EXECUTE, 1, 1, 1, STATE_HALT,    0, 0, 0, 0};
      tbl[9]  = '{STATE_EXECUTE, 1, 0, 0, STATE_FETCH1,  0, 0, 0, 0};
      tbl[10] = '{STATE_HALT,    1, 0, 0, STATE_HALT,    0, 0, 0, 1};
      tbl[11] = '{3'd5,          1, 0, 0, STATE_FETCH1,  0, 0, 0, 0};
      tbl[12] = '{3'd6,          1, 1, 1, STATE_FETCH1,  0, 0, 0, 0};
      tbl[13] = '{3'd7,          0, 0, 0, STATE_FETCH1,  0, 0, 0, 0};
      for (int i = 0; i < 14; i++) begin
         force_st = tbl[i].st;
         mem_ready = tbl[i].rdy;
         inst_is_mem = tbl[i].mem;
         inst_is_halt = tbl[i].hlt;
         #1;
         chk($sformatf("tbl%0d_next", i), 32'(state_next), 32'(tbl[i].nx));
         chk($sformatf("tbl%0d_acc", i), 32'(mem_access), 32'(tbl[i].acc));
         chk($sformatf("tbl%0d_hi", i), 32'(inst_hi_load), 32'(tbl[i].hi));
         chk($sformatf("tbl%0d_lo", i), 32'(inst_lo_load), 32'(tbl[i].lo));
         chk($sformatf("tbl%0d_halted", i), 32'(halted), 32'(tbl[i].hl));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
